// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Ports: cpu_* request side, bram_* data array, mem_* refill/write-through;
// optional hit_cnt/miss_cnt outputs when CACHE_PERF_EN is defined.
module cache_ctrl #(
    parameter int LINES = 32,
    parameter int TAG_W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [2:0]   cpu_mode,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rdata,
    output logic         bram_write,
    output logic         bram_write_line,
    output logic [2:0]   bram_write_mode,
    output logic [12:0]  bram_addr,
    output logic [31:0]  bram_din,
    output logic [511:0] bram_din_line,
    input  logic [31:0]  bram_dout,
    output logic         mem_rreq,
    output logic [31:0]  mem_raddr,
    input  logic         mem_rvalid,
    input  logic [511:0] mem_rline,
    output logic         mem_wreq,
    output logic [31:0]  mem_waddr,
    output logic [31:0]  mem_wdata,
    output logic [2:0]   mem_wmode,
    input  logic         mem_wack
`ifdef CACHE_PERF_EN
   ,output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESP,
        WMEM
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             we_q;
    logic [2:0]       mode_q;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    logic [4:0]  idx;
    logic        hit;
    logic        accept;
    logic        lookup;
    logic [6:0]  boff;
    logic [31:0] fill_data;

    assign idx    = addr_q[10:6];
    assign hit    = valid_q[idx] && (tag_q[idx] == addr_q[31:11]);
    assign accept = (state_q == IDLE) && cpu_req;
    assign lookup = (state_q == LOOKUP);

    // Bytes past the end of the line read as zero.
    always_comb begin
        fill_data = '0;
        boff      = '0;
        for (int i = 0; i < 4; i++) begin
            boff = {1'b0, addr_q[5:0]} + 7'(i);
            if (!boff[6])
                fill_data[8*i +: 8] = mem_rline[{boff[5:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d         = state_q;
        cpu_ready       = 1'b0;
        bram_write      = 1'b0;
        bram_write_line = 1'b0;
        mem_rreq        = 1'b0;
        mem_wreq        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                if (we_q) begin
                    bram_write = hit;
                    state_d    = WMEM;
                end else if (hit) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_rreq = 1'b1;
                if (mem_rvalid) begin
                    bram_write_line = 1'b1;
                    state_d         = RESP;
                end
            end
            RESP: begin
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            WMEM: begin
                mem_wreq = 1'b1;
                if (mem_wack)
                    state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // bram_addr follows cpu_addr on acceptance so data is ready in LOOKUP.
    assign bram_addr       = accept ? cpu_addr[12:0] : addr_q[12:0];
    assign bram_write_mode = mode_q;
    assign bram_din        = wdata_q;
    assign bram_din_line   = bram_write_line ? mem_rline : '0;
    assign mem_raddr       = mem_rreq ? {addr_q[31:6], 6'b0} : '0;
    assign mem_waddr       = mem_wreq ? addr_q : '0;
    assign mem_wdata       = mem_wreq ? wdata_q : '0;
    assign mem_wmode       = mem_wreq ? mode_q : '0;

    always_comb begin
        cpu_rdata = '0;
        if (lookup && !we_q && hit)
            cpu_rdata = bram_dout;
        else if (state_q == RESP && !we_q)
            cpu_rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                we_q    <= cpu_we;
                mode_q  <= cpu_mode;
            end
            if (bram_write_line)
                rdata_q <= fill_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++)
                tag_q[i] <= '0;
        end else if (bram_write_line) begin
            valid_q[idx] <= 1'b1;
            tag_q[idx]   <= addr_q[31:11];
        end
    end

`ifdef CACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (lookup) begin
            if (hit)
                hit_cnt <= hit_cnt + 32'd1;
            else
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter LINES, default 32: number of direct-mapped lines; index = cpu_addr[10:6]; fixed at 32.
REQ-002 Parameter TAG_W, default 21: tag width, cpu_addr[31:11].
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cpu_req  input  1  request; held by the requester until cpu_ready.
REQ-006 cpu_we  input  1  1 = store, 0 = load.
REQ-007 cpu_mode  input  3  000 byte, 001 half, 010 word.
REQ-008 cpu_addr  input  32  byte address, naturally aligned to cpu_mode.
REQ-009 cpu_wdata  input  32  store data, byte at cpu_addr in [7:0].
REQ-010 cpu_ready  output  1  one-cycle completion pulse.
REQ-011 cpu_rdata  output  32  load data, valid with cpu_ready.
REQ-012 bram_write, bram_write_line  output  1 each  data-array partial and full-line write strobes.
REQ-013 bram_write_mode  output  3  mirrors cpu_mode.
REQ-014 bram_addr  output  13  cpu_addr[12:0].
REQ-015 bram_din  output  32; bram_din_line  output  512  data-array write data.
REQ-016 bram_dout  input  32  data-array read data, one cycle after bram_addr.
REQ-017 mem_rreq  output  1; mem_raddr  output  32; mem_rvalid  input  1; mem_rline  input  512  line refill.
REQ-018 mem_wreq  output  1; mem_waddr  output  32; mem_wdata  output  32; mem_wmode  output  3; mem_wack  input  1  write-through.

Function
REQ-019 States: IDLE, LOOKUP, REFILL, RESP, WMEM.
REQ-020 IDLE: with cpu_req=1, the block latches addr/we/mode/wdata, drives bram_addr from cpu_addr, and enters LOOKUP.
REQ-021 LOOKUP: hit = valid[index] and tag[index]==addr[31:11].
REQ-022 Load hit: cpu_ready=1 and cpu_rdata=bram_dout in the LOOKUP cycle, then the block returns to IDLE; latency is 1 cycle after acceptance.
REQ-023 Load miss: enter REFILL; mem_rreq=1, mem_raddr={addr[31:6],6'b0} held until mem_rvalid.
REQ-024 mem_rvalid in REFILL: bram_write_line=1, bram_din_line=mem_rline, tag/valid written, and cpu_rdata registered from mem_rline bytes addr[5:0]..+3; then RESP.
REQ-025 RESP: cpu_ready=1 for one cycle, then IDLE.
REQ-026 Store: on a hit in LOOKUP, bram_write=1 for exactly one cycle with bram_din=wdata; a store miss does not allocate; both cases enter WMEM.
REQ-027 WMEM: mem_wreq=1 with mem_waddr=addr, mem_wdata=wdata, mem_wmode=mode held until mem_wack; on mem_wack, go to RESP.
REQ-028 cpu_req outside IDLE is ignored; the earliest next acceptance is the cycle after cpu_ready.
REQ-029 mem_rvalid outside REFILL and mem_wack outside WMEM are ignored.
REQ-030 A store hit followed by a load to the same address returns the stored bytes.
REQ-031 A refill replaces the line's tag unconditionally (no dirty state).

Reset
REQ-032 rst_n low: state IDLE; all valid bits 0; every output 0 (cpu_ready, cpu_rdata, strobes, mem_rreq, mem_wreq, addresses, data).
REQ-033 Reset during REFILL/WMEM aborts the request: mem_rreq/mem_wreq drop asynchronously, and no tag or data-array write occurs.

Configuration
REQ-034 CACHE_PERF_EN defined: outputs hit_cnt and miss_cnt (32 bits each) count LOOKUP hits and misses (loads and stores), wrap at 2^32, and are cleared by reset.
REQ-035 CACHE_PERF_EN undefined: the hit_cnt and miss_cnt ports and counters are absent; all other behaviour is identical.

Verification
REQ-036 After reset, word load 0x0000_1040 -> mem_rreq with mem_raddr=0x0000_1040; mem_rline byte 0..3 = 11 22 33 44 -> bram_write_line=1, then cpu_ready with cpu_rdata=0x44332211.
REQ-037 Repeat the load of 0x0000_1040 -> no mem_rreq; cpu_ready 1 cycle after acceptance with data 0x44332211.
REQ-038 Half store 0xBEEF to 0x0000_1042 (hit) -> one-cycle bram_write with mode 001; mem_wreq held 3 cycles until mem_wack; cpu_ready follows.
REQ-039 Load 0x0000_3040 (same index, different tag) -> miss, refill, tag replaced; a subsequent load of 0x0000_1040 misses again.
REQ-040 rst_n low while mem_rreq is pending, then a later mem_rvalid -> no bram_write_line, valid stays 0, cpu_ready never asserted.
REQ-041 With CACHE_PERF_EN: sequence miss, hit, store-hit -> hit_cnt=2, miss_cnt=1.
